// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one 8N1 UART transmitter between NREQ byte producers. A byte is
// accepted from one requester at a time (round robin, scanning upward from
// the requester after the last owner), handed to the transmitter through
// tx_byte/tx_send, and the frame is tracked through the transmitter's
// tx_done level. A watchdog abandons a frame the transmitter never finishes.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  hwclk cycles allowed from start of send to frame done
//
// Ports
//   hwclk        in   system clock, all state on its rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NREQ]    requester i has a byte pending
//   req_data     in   [8*NREQ]  byte of requester i in bits [8i+7:8i]
//   req_ready    out  [NREQ]    one-cycle pulse: requester i's byte latched
//   tx_byte      out  [8]       byte to the transmitter
//   tx_send      out            send request to the transmitter
//   tx_done      in             transmitter idle/done level (other domain)
//   grant        out  [NREQ]    one-hot owner of the current frame
//   busy         out            a frame is being sequenced
//   timeout_err  out            sticky watchdog flag, cleared by reset only
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic                hwclk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          tx_byte,
    output logic                tx_send,
    input  logic                tx_done,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                timeout_err
);

    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            done_meta_q, done_meta_d;
    logic            done_s_q, done_s_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_send_q, tx_send_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    // Candidate gi is the requester gi places above the pointer (mod NREQ).
    // The lowest-offset candidate with valid set wins.
    logic [PW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [PW:0] sum;
        assign sum           = {1'b0, ptr_q} + (PW+1)'(gi);
        assign cand_idx[gi]  = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                      : sum[PW-1:0];
        assign cand_hit[gi]  = req_valid[cand_idx[gi]];
    end

    logic          sel_found;
    logic [PW-1:0] sel_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        // Descending scan so the smallest offset is the last (winning) write.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx[k];
            end
        end
    end

    logic [PW-1:0] next_ptr;
    assign next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        done_meta_d = tx_done;
        done_s_d    = done_meta_q;

        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wdog_d      = wdog_q;
        req_ready_d = '0;
        tx_byte_d   = tx_byte_q;
        tx_send_d   = tx_send_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    owner_d     = sel_idx;
                    tx_byte_d   = req_data[{sel_idx, 3'b000} +: 8];
                    req_ready_d = NREQ'(1) << sel_idx;
                    grant_d     = NREQ'(1) << sel_idx;
                    busy_d      = 1'b1;
                    tx_send_d   = 1'b1;
                    wdog_d      = '0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND, ST_WAIT_DONE: begin
                if (wdog_q == WDOG_LIMIT) begin
                    // Transmitter never finished: drop the byte, move on.
                    err_d     = 1'b1;
                    tx_send_d = 1'b0;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = next_ptr;
                    state_d   = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (state_q == ST_SEND && !done_s_q) begin
                        // Transmitter has started the frame.
                        tx_send_d = 1'b0;
                        state_d   = ST_WAIT_DONE;
                    end else if (state_q == ST_WAIT_DONE && done_s_q) begin
                        grant_d = '0;
                        busy_d  = 1'b0;
                        ptr_d   = next_ptr;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_send_d = 1'b0;
                grant_d   = '0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // tx_done comes from the baud-clock domain: two-flop synchronizer,
    // reset to the transmitter's idle level.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            done_meta_q <= 1'b1;
            done_s_q    <= 1'b1;
        end else begin
            done_meta_q <= done_meta_d;
            done_s_q    <= done_s_d;
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            wdog_q      <= '0;
            req_ready_q <= '0;
            tx_byte_q   <= 8'h00;
            tx_send_q   <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wdog_q      <= wdog_d;
            req_ready_q <= req_ready_d;
            tx_byte_q   <= tx_byte_d;
            tx_send_q   <= tx_send_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_byte     = tx_byte_q;
    assign tx_send     = tx_send_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 100;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_byte;
    logic              tx_send;
    logic              tx_done;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              timeout_err;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .hwclk       (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_byte     (tx_byte),
        .tx_send     (tx_send),
        .tx_done     (tx_done),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model (frame-level rules) ----------------
    int              m_mode  = 0;   // 0 idle, 1 waiting for start, 2 waiting for done
    int              m_ptr   = 0;
    int              m_owner = 0;
    int              m_gcyc  = 0;
    int              m_cyc   = 0;
    bit              m_d1 = 1'b1, m_d2 = 1'b1;   // tx_done as seen 1 and 2 edges ago
    logic [NREQ-1:0] e_ready = '0, e_grant = '0;
    logic [7:0]      e_byte  = 8'h00;
    bit              e_send = 0, e_busy = 0, e_err = 0;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_d1 = 1'b1; m_d2 = 1'b1;
        e_ready = '0; e_grant = '0; e_byte = 8'h00;
        e_send = 0; e_busy = 0; e_err = 0;
    endtask

    task automatic model_finish();
        e_send  = 0;
        e_grant = '0;
        e_busy  = 0;
        m_ptr   = (m_owner + 1) % NREQ;
        m_mode  = 0;
    endtask

    task automatic model_step();
        bit ds;
        int g;
        m_cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ds = m_d2; m_d2 = m_d1; m_d1 = tx_done;
        e_ready = '0;
        if (m_mode == 0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            if (g >= 0) begin
                e_ready = NREQ'(1) << g;
                e_grant = e_ready;
                e_byte  = req_data[g*8 +: 8];
                e_send  = 1; e_busy = 1;
                m_mode  = 1; m_owner = g; m_gcyc = m_cyc;
            end
        end else begin
            if (m_cyc - m_gcyc == TIMEOUT + 1) begin
                e_err = 1;
                model_finish();
            end else if (m_mode == 1 && !ds) begin
                e_send = 0;
                m_mode = 2;
            end else if (m_mode == 2 && ds) begin
                model_finish();
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_grant", grant, 0);
            check("rst_tx_send", tx_send, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("out_req_ready", req_ready, e_ready);
            check("out_grant", grant, e_grant);
            check("out_tx_byte", tx_byte, e_byte);
            check("out_tx_send", tx_send, e_send);
            check("out_busy", busy, e_busy);
            check("out_timeout_err", timeout_err, e_err);
        end
    end

    // ---------------- requester side ----------------
    int ack_q[$];
    int gap_q[$];
    int ready_cnt[NREQ];
    int grant1_cnt = 0;
    int refill_cnt = 0;
    int last_fall  = 0;
    bit prev_busy  = 0;

    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_busy && !busy) last_fall = cyc;
            prev_busy = busy;
            if (grant[1]) grant1_cnt++;
            for (int i = 0; i < NREQ; i++) begin
                if (rst_n && req_ready[i]) begin
                    $display("ack req=%0d byte=%02h cyc=%0d", i, tx_byte, cyc);
                    ack_q.push_back(i);
                    gap_q.push_back(cyc - last_fall);
                    ready_cnt[i]++;
                    if (refill_cnt > 0) begin
                        refill_cnt--;
                        req_data[i*8 +: 8] = 8'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- transmitter model ----------------
    int tx_phase = 0;   // 0 idle, 1 start delay, 2 shifting, 3 stuck
    int tx_cnt   = 0;
    int tx_dly   = 5;
    int tx_len   = 40;
    bit rand_tx  = 0;
    bit stuck_once = 0;
    int fall_cyc = 0, rise_cyc = 0;

    initial begin
        tx_done = 1'b1;
        forever begin
            @(negedge clk);
            case (tx_phase)
                0: if (tx_send) begin
                    if (stuck_once || (rand_tx && $urandom_range(0, 7) == 0)) begin
                        stuck_once = 0;
                        tx_phase   = 3;
                    end else begin
                        tx_cnt   = rand_tx ? $urandom_range(1, 8) : tx_dly;
                        tx_phase = 1;
                    end
                end
                1: begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done  = 1'b0;
                        fall_cyc = cyc;
                        tx_cnt   = rand_tx ? $urandom_range(10, 60) : tx_len;
                        tx_phase = 2;
                    end
                end
                2: begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done  = 1'b1;
                        rise_cyc = cyc;
                        tx_phase = 0;
                    end
                end
                default: if (!tx_send) tx_phase = 0;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
        req_valid[i]       = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int max_cyc);
        for (int k = 0; k < max_cyc && ack_q.size() < n; k++) tick();
        check("ack_count", ack_q.size(), n);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int k = 0; k < max_cyc && (busy || req_valid != 0 || tx_phase != 0); k++) tick();
        check("idle_reached", {31'd0, (busy || req_valid != 0 || tx_phase != 0)}, 0);
    endtask

    task automatic clear_logs();
        ack_q.delete();
        gap_q.delete();
        for (int i = 0; i < NREQ; i++) ready_cnt[i] = 0;
        grant1_cnt = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed + random sequence ----------------
    int rot_exp[6] = '{0, 1, 2, 3, 0, 1};
    int k;
    int c0;
    int n;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_tx_byte", tx_byte, 8'h00);
        check("reset_err", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        // Single requester 2 with 0x41
        clear_logs();
        set_req(2, 8'h41);
        wait_acks(1, 20);
        check("single_ready", req_ready, 4'b0100);
        check("single_grant", grant, 4'b0100);
        check("single_byte", tx_byte, 8'h41);
        for (k = 0; k < 200 && tx_send; k++) tick();
        check("send_drop_latency", cyc - fall_cyc, 3);
        for (k = 0; k < 200 && busy; k++) tick();
        check("busy_drop_latency", cyc - rise_cyc, 3);
        check("single_ready_count", ready_cnt[2], 1);
        wait_idle(50);

        // Pointer now 3: requesters 1 and 3 together -> 3 first
        clear_logs();
        set_req(1, 8'h11);
        set_req(3, 8'h33);
        wait_acks(2, 400);
        check("ptr3_first", ack_q[0], 3);
        check("ptr3_second", ack_q[1], 1);
        wait_idle(200);

        // Reset mid-frame (pointer 2 -> requester 2 granted)
        clear_logs();
        set_req(2, 8'h5A);
        wait_acks(1, 20);
        check("rst_pre_grant", ack_q[0], 2);
        for (k = 0; k < 200 && tx_send; k++) tick();
        check("rst_pre_busy", busy, 1);
        #2;
        c0    = cyc;
        rst_n = 1'b0;
        #1;
        check("rst_async_ready", req_ready, 0);
        check("rst_async_grant", grant, 0);
        check("rst_async_byte", tx_byte, 8'h00);
        check("rst_async_send", tx_send, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_noedge", cyc, c0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_idle(200);

        // Simultaneous 0 and 3 with pointer 0
        clear_logs();
        set_req(0, 8'hA0);
        set_req(3, 8'hA3);
        wait_acks(2, 400);
        check("simul_first", ack_q[0], 0);
        check("simul_second", ack_q[1], 3);
        check("simul_idle_gap", gap_q[1], 1);
        wait_idle(200);

        // Rotation with continuously valid requesters
        clear_logs();
        refill_cnt = 2;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom));
        wait_acks(6, 1000);
        for (int i = 0; i < 6; i++) check($sformatf("rotation_%0d", i), ack_q[i], rot_exp[i]);
        wait_idle(400);

        // Watchdog: transmitter never starts (pointer 2)
        clear_logs();
        stuck_once = 1;
        set_req(2, 8'hE2);
        set_req(3, 8'hE3);
        wait_acks(1, 20);
        check("wdog_first", ack_q[0], 2);
        n = 0;
        while (tx_send && n < 300) begin
            n++;
            tick();
        end
        check("wdog_send_cycles", n, TIMEOUT + 1);
        check("wdog_err_set", timeout_err, 1);
        wait_acks(2, 20);
        check("wdog_next", ack_q[1], 3);
        wait_idle(200);
        check("wdog_err_sticky", timeout_err, 1);

        // Withdrawn request while busy (pointer 0)
        clear_logs();
        set_req(0, 8'hC0);
        wait_acks(1, 20);
        tick();
        tick();
        set_req(1, 8'hC1);
        tick();
        req_valid[1] = 1'b0;
        wait_idle(200);
        repeat (5) tick();
        check("withdraw_no_ready", ready_cnt[1], 0);
        check("withdraw_no_grant", grant1_cnt, 0);

        // Randomized traffic, withdrawals and occasional stuck frames
        rand_tx = 1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 15) == 0)
                    set_req(i, 8'($urandom));
                else if (req_valid[i] && $urandom_range(0, 63) == 0)
                    req_valid[i] = 1'b0;
            end
        end
        wait_idle(3000);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single `uart_tx_8n1` transmitter between `NREQ` byte producers, such as a digit counter, a keypad scanner and a status reporter. It runs on the 12 MHz `hwclk` and accepts one byte at a time from the requesters over a valid/ready handshake. It drives the transmitter's `txbyte`/`senddata` inputs and tracks the frame through the transmitter's `txdone` level. A watchdog recovers the block if the transmitter never completes a frame.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 20000: `hwclk` cycles allowed from start of send to frame done. This must exceed one 8N1 frame at the baud clock in use; 9600 baud is about 12500 cycles.
- `hwclk`, in, 1: 12 MHz system clock. All state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NREQ: requester i has a byte pending. It must hold `req_data` stable while high.
- `req_data`, in, 8*NREQ: byte of requester i in bits [8i+7:8i].
- `req_ready`, out, NREQ: one-cycle pulse. Requester i's byte has been latched, and the requester may drop valid or present its next byte.
- `tx_byte`, out, 8: byte to the transmitter's `txbyte`.
- `tx_send`, out, 1: request to the transmitter's `senddata`.
- `tx_done`, in, 1: transmitter `txdone` level from the baud-clock domain. High means idle/done, low means transmitting.
- `grant`, out, NREQ: one-hot owner of the current frame, all zero when idle.
- `busy`, out, 1: a frame is being sequenced.
- `timeout_err`, out, 1: sticky. Set when the watchdog fires, cleared only by reset.

## Operation
- **Reset values** (`rst_n` low, asynchronous):
  - Outputs: `req_ready`=0, `tx_byte`=0x00, `tx_send`=0, `grant`=0, `busy`=0, `timeout_err`=0.
  - Internal: pointer=0, state IDLE, watchdog=0.
  - `tx_done` synchronizer flops reset to 1.
- **tx_done synchronization:** `tx_done` passes through 2 flops; the state machine sees only the synchronized value (`done_s`).
- **IDLE:**
  - If any `req_valid` bit is set, select the first set bit scanning upward from the pointer, modulo `NREQ`. Call it index g.
  - Latch `req_data[g]` into `tx_byte`, pulse `req_ready[g]`, set `grant[g]`=1 and `busy`=1, clear the watchdog, and go to SEND.
  - If no bit is set, stay in IDLE.
- **SEND:**
  - `tx_send`=1 and `tx_byte` is held.
  - When `done_s`=0 (transmitter started), drop `tx_send` and go to WAIT_DONE.
- **WAIT_DONE:**
  - `tx_send`=0.
  - When `done_s`=1, the frame is finished: clear `grant` and `busy`, set pointer = (g+1) mod `NREQ`, and go to IDLE.
- **Watchdog:**
  - Increments every cycle in SEND and WAIT_DONE.
  - When it reaches `TIMEOUT`: set `timeout_err`, drop `tx_send`, clear `grant` and `busy`, advance the pointer as on normal completion, and go to IDLE.
  - The byte is dropped and is not retried.
- **Requests during a frame:** `req_valid` in SEND or WAIT_DONE is ignored. Requesters wait; no request is ever lost or double-acked.
- **Withdrawn request:** a requester that drops `req_valid` before being granted is simply skipped.
- **Fairness:** if all requesters are continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 frames.
- **Reset mid-frame:** all state returns to reset values immediately. The pending frame is abandoned, and any byte already on the transmitter completes on its own.
- **State encoding:** IDLE/SEND/WAIT_DONE. Unreachable encodings return to IDLE.

## Timing
- **Grant latency:** valid sampled in IDLE at edge k makes `req_ready`, `grant`, `tx_byte`, `tx_send` and `busy` valid after edge k. All outputs are registered.
- **`req_ready` width:** exactly 1 cycle per accepted byte.
- **`tx_done` latency:** 2 synchronizer cycles plus 1 decision cycle.
  - `tx_done` falling → `tx_send` drops 3 cycles later.
  - `tx_done` rising → `busy` drops 3 cycles later.
- **Back-to-back frames:** the earliest next grant is the cycle after return to IDLE, so there is a minimum 1 idle cycle of `busy`=0 between frames.
- **Watchdog timing:** fires on the cycle the count equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after `tx_send` rose.

## Test plan
- **Single requester:**
  - Stimulus: `NREQ`=4, requester 2 valid with 0x41; model transmitter drops `tx_done` 50 cycles after `tx_send`, raises it 12500 cycles later.
  - Required: one `req_ready[2]` pulse, `grant`=0100, `tx_byte`=0x41, `busy` low 3 cycles after `tx_done` rises, pointer=3.
- **Simultaneous requesters:**
  - Stimulus: requesters 0 and 3 valid at once, pointer=0.
  - Required: byte of 0 sent first, then 3; `req_ready[3]` only after `busy` falls.
- **Rotation and wrap:**
  - Stimulus: all four continuously valid for 6 frames.
  - Required: grant order 0,1,2,3,0,1; pointer wraps 3→0.
- **Watchdog:**
  - Stimulus: `TIMEOUT`=100, `tx_done` stuck high.
  - Required: `tx_send` high 101 cycles then low, `timeout_err`=1 sticky, next requester granted afterwards.
- **Reset mid-frame:**
  - Stimulus: assert `rst_n` low in WAIT_DONE.
  - Required: all outputs at reset values immediately, without a clock edge; after release, pointer=0 and a new request is granted normally.
- **Withdrawn request:**
  - Stimulus: requester 1 pulses valid for 1 cycle while `busy`.
  - Required: no `req_ready[1]` and no grant to 1.
